// File: rtl/sar_adc_pkg.sv
// ---------------------------------------------------------------------------
// sar_adc_pkg
//   Shared definitions for the SAR ADC sequencer slice.
//   - seq_state_t : sequencer FSM states (IDLE, CONVERT, WAIT)
//   - cnt_width() : width of a counter that must hold 0 .. value-1
//                   (clog2 of the value, never less than one bit)
// ---------------------------------------------------------------------------
package sar_adc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    WAIT    = 2'd2
  } seq_state_t;

  // Width of a counter running 0 .. value-1.
  // Tiny values still get one bit so the declared vector stays legal.
  function automatic int cnt_width(input int value);
    if (value <= 2) begin
      return 1;
    end
    return $clog2(value);
  endfunction

endpackage

// File: rtl/avg_output_reg.sv
// ---------------------------------------------------------------------------
// avg_output_reg
//   Holding register for the averaged ADC result with a valid/ready
//   handshake and a sticky overrun flag.
//
// Ports
//   clk                 in   clock, rising edge
//   reset               in   synchronous, active-high
//   load                in   one-cycle strobe: capture load_data
//   load_data           in   [N_BITS] new averaged value
//   avg_ready           in   consumer ready; transfer when valid & ready
//   avg_result_digital  out  [N_BITS] held averaged value
//   avg_valid           out  avg_result_digital holds an unconsumed value
//   overrun             out  sticky; an unconsumed value was overwritten
// ---------------------------------------------------------------------------
module avg_output_reg #(
  parameter int N_BITS = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [N_BITS-1:0] load_data,
  input  logic              avg_ready,
  output logic [N_BITS-1:0] avg_result_digital,
  output logic              avg_valid,
  output logic              overrun
);

  // A load always wins over a handshake: the new value lands and valid
  // stays high. The old value counts as lost only when the consumer was
  // not taking it in that same cycle, which is the only case that flags
  // overrun. Overrun is cleared by reset alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      avg_result_digital <= '0;
      avg_valid          <= 1'b0;
      overrun            <= 1'b0;
    end else if (load) begin
      avg_result_digital <= load_data;
      avg_valid          <= 1'b1;
      if (avg_valid && !avg_ready) begin
        overrun <= 1'b1;
      end
    end else if (avg_valid && avg_ready) begin
      avg_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/sar_adc_sequencer.sv
// ---------------------------------------------------------------------------
// sar_adc_sequencer
//   Periodically triggers a SAR ADC, collects 2**AVG_LOG2 conversion
//   results, and presents their truncated mean on a valid/ready output.
//   Conversion starts are exactly PERIOD cycles apart while enable is high.
//   A conversion that does not report adc_eoc within TIMEOUT cycles is
//   abandoned and flags timeout_err.
//
// Parameters
//   N_BITS    ADC result width
//   AVG_LOG2  log2 of conversions averaged per output (0 = pass-through)
//   PERIOD    cycles between conversion starts (must be >= TIMEOUT+4)
//   TIMEOUT   max cycles to wait for adc_eoc
//
// Ports
//   clk                 in   clock, rising edge
//   reset               in   synchronous, active-high
//   enable              in   level; high permits conversions to start
//   adc_hold_digital    out  ADC sample-and-hold / SAR start
//   adc_eoc             in   ADC end-of-conversion
//   adc_result_digital  in   [N_BITS] ADC conversion result
//   avg_result_digital  out  [N_BITS] averaged result
//   avg_valid           out  avg_result_digital is valid
//   avg_ready           in   consumer accepts when valid & ready
//   overrun             out  sticky; an unaccepted result was overwritten
//   timeout_err         out  sticky; a conversion exceeded TIMEOUT
//   busy                out  sequencer is not IDLE
// ---------------------------------------------------------------------------
module sar_adc_sequencer
  import sar_adc_pkg::*;
#(
  parameter int N_BITS   = 10,
  parameter int AVG_LOG2 = 2,
  parameter int PERIOD   = 64,
  parameter int TIMEOUT  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic              adc_hold_digital,
  input  logic              adc_eoc,
  input  logic [N_BITS-1:0] adc_result_digital,
  output logic [N_BITS-1:0] avg_result_digital,
  output logic              avg_valid,
  input  logic              avg_ready,
  output logic              overrun,
  output logic              timeout_err,
  output logic              busy
);

  // Period and timeout counters share one width; TIMEOUT < PERIOD, so a
  // counter sized for PERIOD also covers the timeout range.
  localparam int CNT_W = cnt_width(PERIOD);
  // Enough headroom for 2**AVG_LOG2 full-scale results: cannot overflow.
  localparam int ACC_W = N_BITS + AVG_LOG2;
  localparam int SMP_W = AVG_LOG2 + 1;

  localparam logic [SMP_W-1:0] N_SAMPLES    = SMP_W'(1 << AVG_LOG2);
  localparam logic [CNT_W-1:0] PERIOD_LAST  = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

  seq_state_t        state_q, state_d;
  logic              hold_q, hold_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic [CNT_W-1:0]  timeout_q, timeout_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [SMP_W-1:0]  smp_q, smp_d;
  logic              timeout_err_q, timeout_err_d;
  logic              avg_load;
  logic [N_BITS-1:0] avg_data;

  // State and datapath registers. Everything returns to a quiet IDLE on
  // reset, which also drops adc_hold_digital on the very next edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      hold_q        <= 1'b0;
      period_q      <= '0;
      timeout_q     <= '0;
      acc_q         <= '0;
      smp_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      period_q      <= period_d;
      timeout_q     <= timeout_d;
      acc_q         <= acc_d;
      smp_q         <= smp_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Next-state and datapath control.
  // hold_d is the registered value of adc_hold_digital, so it is high
  // exactly for the cycles spent in CONVERT. The period counter is zeroed
  // on every CONVERT entry and free-runs through CONVERT and WAIT; leaving
  // WAIT on PERIOD_LAST spaces consecutive starts exactly PERIOD apart.
  // A full sample set is unloaded the cycle after the last eoc, which is
  // always early in WAIT, so it never collides with an eoc or a WAIT exit.
  always_comb begin
    state_d       = state_q;
    hold_d        = 1'b0;
    period_d      = period_q + 1'b1;
    timeout_d     = timeout_q;
    acc_d         = acc_q;
    smp_d         = smp_q;
    timeout_err_d = timeout_err_q;
    avg_load      = 1'b0;

    if (smp_q == N_SAMPLES) begin
      avg_load = 1'b1;
      acc_d    = '0;
      smp_d    = '0;
    end

    unique case (state_q)
      IDLE: begin
        period_d  = '0;
        timeout_d = '0;
        if (enable) begin
          state_d = CONVERT;
          hold_d  = 1'b1;
        end
      end

      CONVERT: begin
        timeout_d = timeout_q + 1'b1;
        if (adc_eoc) begin
          acc_d   = acc_q + ACC_W'(adc_result_digital);
          smp_d   = smp_q + 1'b1;
          state_d = WAIT;
        end else if (timeout_q == TIMEOUT_LAST) begin
          // A lost conversion poisons the running average; restart it.
          timeout_err_d = 1'b1;
          acc_d         = '0;
          smp_d         = '0;
          state_d       = WAIT;
        end else begin
          hold_d = 1'b1;
        end
      end

      WAIT: begin
        if (period_q == PERIOD_LAST) begin
          period_d  = '0;
          timeout_d = '0;
          if (enable) begin
            state_d = CONVERT;
            hold_d  = 1'b1;
          end else begin
            // Partial sample sets do not survive a stop.
            state_d = IDLE;
            acc_d   = '0;
            smp_d   = '0;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Truncating mean: drop the AVG_LOG2 fractional bits.
  assign avg_data = N_BITS'(acc_q >> AVG_LOG2);

  assign adc_hold_digital = hold_q;
  assign timeout_err      = timeout_err_q;
  assign busy             = (state_q != IDLE);

  avg_output_reg #(
    .N_BITS (N_BITS)
  ) u_avg_output_reg (
    .clk                (clk),
    .reset              (reset),
    .load               (avg_load),
    .load_data          (avg_data),
    .avg_ready          (avg_ready),
    .avg_result_digital (avg_result_digital),
    .avg_valid          (avg_valid),
    .overrun            (overrun)
  );

endmodule

// File: tb/tb_sar_adc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sar_adc_sequencer
//   Self-checking bench for sar_adc_sequencer with default parameters.
//   An ADC model answers each conversion after eoc_delay cycles of hold,
//   taking results from adc_q. Tests push the expected averages into exp_q;
//   a monitor pops and compares one entry per output handshake.
// ---------------------------------------------------------------------------
module tb_sar_adc_sequencer;

  localparam int N_BITS   = 10;
  localparam int AVG_LOG2 = 2;
  localparam int PERIOD   = 64;
  localparam int TIMEOUT  = 32;

  logic              clk;
  logic              reset;
  logic              enable;
  logic              adc_hold_digital;
  logic              adc_eoc;
  logic [N_BITS-1:0] adc_result_digital;
  logic [N_BITS-1:0] avg_result_digital;
  logic              avg_valid;
  logic              avg_ready;
  logic              overrun;
  logic              timeout_err;
  logic              busy;

  int checks;
  int errors;
  int cyc;
  int eoc_delay;
  bit spurious_eoc;
  int hold_cnt;
  int eoc_count;
  int hs_count;

  logic [N_BITS-1:0] adc_q[$];
  logic [N_BITS-1:0] exp_q[$];

  sar_adc_sequencer #(
    .N_BITS   (N_BITS),
    .AVG_LOG2 (AVG_LOG2),
    .PERIOD   (PERIOD),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .enable             (enable),
    .adc_hold_digital   (adc_hold_digital),
    .adc_eoc            (adc_eoc),
    .adc_result_digital (adc_result_digital),
    .avg_result_digital (avg_result_digital),
    .avg_valid          (avg_valid),
    .avg_ready          (avg_ready),
    .overrun            (overrun),
    .timeout_err        (timeout_err),
    .busy               (busy)
  );

  // Free-running clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ADC model: counts hold cycles and answers on the eoc_delay-th one.
  // With spurious_eoc set it also raises eoc (with junk data) whenever
  // hold is low, which the sequencer must ignore.
  initial begin
    adc_eoc            = 1'b0;
    adc_result_digital = '0;
    hold_cnt           = 0;
    eoc_count          = 0;
    forever begin
      @(negedge clk);
      if (adc_hold_digital === 1'b1) hold_cnt++;
      else hold_cnt = 0;
      if (adc_hold_digital === 1'b1 && eoc_delay != 0 && hold_cnt == eoc_delay) begin
        adc_eoc            = 1'b1;
        adc_result_digital = (adc_q.size() != 0) ? adc_q.pop_front() : '0;
        eoc_count++;
      end else if (adc_hold_digital !== 1'b1 && spurious_eoc) begin
        adc_eoc            = 1'b1;
        adc_result_digital = 10'd1000;
      end else begin
        adc_eoc            = 1'b0;
        adc_result_digital = 10'h2AA;
      end
    end
  end

  // Scoreboard monitor: every output handshake consumes one expected value
  initial begin
    hs_count = 0;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && avg_valid === 1'b1 && avg_ready === 1'b1) begin
        hs_count++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL handshake_unexpected: got %0d, required no output", avg_result_digital);
        end else begin
          logic [N_BITS-1:0] exp_v;
          exp_v = exp_q.pop_front();
          if (avg_result_digital !== exp_v) begin
            errors++;
            $display("[TB] FAIL handshake_value: got %0d, required %0d", avg_result_digital, exp_v);
          end
        end
      end
    end
  end

  // Watchdog
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_hold(input logic level, input int bound, output bit ok);
    int n;
    n = 0;
    while (adc_hold_digital !== level && n < bound) begin
      @(posedge clk);
      #1;
      n++;
    end
    ok = (adc_hold_digital === level);
  endtask

  task automatic wait_idle(input int bound, output bit ok);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < bound) begin
      @(posedge clk);
      #1;
      n++;
    end
    ok = (busy === 1'b0);
  endtask

  task automatic wait_eoc(input int target, input int bound, output bit ok);
    int n;
    n = 0;
    while (eoc_count < target && n < bound) begin
      @(posedge clk);
      #1;
      n++;
    end
    ok = (eoc_count >= target);
  endtask

  task automatic wait_hs(input int target, input int bound, output bit ok);
    int n;
    n = 0;
    while (hs_count < target && n < bound) begin
      @(posedge clk);
      #1;
      n++;
    end
    ok = (hs_count >= target);
  endtask

  // Reset state of every output
  task automatic test_reset;
    checks++; if (adc_hold_digital !== 1'b0) begin errors++; $display("[TB] FAIL reset_hold: got %b, required 0", adc_hold_digital); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b, required 0", busy); end
    checks++; if (avg_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b, required 0", avg_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun: got %b, required 0", overrun); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout_err: got %b, required 0", timeout_err); end
    checks++; if (avg_result_digital !== '0) begin errors++; $display("[TB] FAIL reset_result: got %0d, required 0", avg_result_digital); end
  endtask

  // 100..103 averaged to 101, with eoc noise outside CONVERT
  task automatic test_average;
    bit ok;
    int h;
    avg_ready = 1'b1; eoc_delay = 12; spurious_eoc = 1'b1;
    for (int i = 0; i < 4; i++) adc_q.push_back(N_BITS'(100 + i));
    exp_q.push_back(10'd101);
    h = hs_count;
    enable = 1'b1;
    wait_hs(h + 1, 400, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL average_handshake: got %0d outputs, required 1", hs_count - h); end
    checks++; if (avg_valid !== 1'b0) begin errors++; $display("[TB] FAIL average_pulse: valid %b after handshake, required 0", avg_valid); end
    enable = 1'b0; spurious_eoc = 1'b0;
    wait_idle(100, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL average_idle: busy %b, required 0", busy); end
    checks++; if (hs_count != h + 1) begin errors++; $display("[TB] FAIL average_count: got %0d outputs, required 1", hs_count - h); end
  endtask

  // Two averages while the consumer stalls: 300 overwrites 200
  task automatic test_overrun;
    bit ok;
    int e, h;
    avg_ready = 1'b0; eoc_delay = 12;
    for (int i = 0; i < 4; i++) adc_q.push_back(10'd200);
    for (int i = 0; i < 4; i++) adc_q.push_back(10'd300);
    exp_q.push_back(10'd300);
    e = eoc_count; h = hs_count;
    enable = 1'b1;
    wait_eoc(e + 4, 400, ok);
    cycles(1);
    checks++; if (!ok || avg_valid !== 1'b1 || avg_result_digital !== 10'd200) begin errors++; $display("[TB] FAIL overrun_first: valid %b value %0d, required 1 and 200", avg_valid, avg_result_digital); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL overrun_early: got %b, required 0", overrun); end
    wait_eoc(e + 8, 400, ok);
    cycles(1);
    checks++; if (!ok || avg_valid !== 1'b1 || avg_result_digital !== 10'd300) begin errors++; $display("[TB] FAIL overrun_second: valid %b value %0d, required 1 and 300", avg_valid, avg_result_digital); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL overrun_flag: got %b, required 1", overrun); end
    enable = 1'b0; avg_ready = 1'b1;
    wait_hs(h + 1, 10, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL overrun_drain: got %0d outputs, required 1", hs_count - h); end
    wait_idle(100, ok);
  endtask

  // No eoc: hold falls after TIMEOUT, next start PERIOD after the last
  task automatic test_timeout;
    bit ok;
    int t0, t1, t2;
    avg_ready = 1'b1; eoc_delay = 0;
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL timeout_pre: got %b, required 0", timeout_err); end
    enable = 1'b1;
    wait_hold(1'b1, 10, ok);
    t0 = cyc;
    checks++; if (!ok) begin errors++; $display("[TB] FAIL timeout_start: hold %b, required 1", adc_hold_digital); end
    wait_hold(1'b0, 60, ok);
    t1 = cyc;
    checks++; if (!ok || t1 - t0 != TIMEOUT) begin errors++; $display("[TB] FAIL timeout_hold_len: got %0d cycles, required %0d", t1 - t0, TIMEOUT); end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("[TB] FAIL timeout_flag: got %b, required 1", timeout_err); end
    wait_hold(1'b1, 60, ok);
    t2 = cyc;
    checks++; if (!ok || t2 - t0 != PERIOD) begin errors++; $display("[TB] FAIL timeout_period: got %0d cycles, required %0d", t2 - t0, PERIOD); end
    enable = 1'b0;
    wait_idle(100, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL timeout_idle: busy %b, required 0", busy); end
  endtask

  // Stop after 2 of 4 samples: no output, and the partial set is dropped
  task automatic test_enable_drop;
    bit ok;
    int e, h;
    avg_ready = 1'b1; eoc_delay = 12;
    adc_q.push_back(10'd500); adc_q.push_back(10'd500);
    e = eoc_count; h = hs_count;
    enable = 1'b1;
    wait_eoc(e + 2, 200, ok);
    cycles(2);
    enable = 1'b0;
    wait_idle(80, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL drop_idle: busy %b, required 0", busy); end
    checks++; if (avg_valid !== 1'b0 || hs_count != h) begin errors++; $display("[TB] FAIL drop_no_output: valid %b outputs %0d, required 0 and 0", avg_valid, hs_count - h); end
    for (int i = 0; i < 4; i++) adc_q.push_back(10'd40);
    exp_q.push_back(10'd40);
    enable = 1'b1;
    wait_hs(h + 1, 400, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL drop_restart: got %0d outputs, required 1", hs_count - h); end
    enable = 1'b0;
    wait_idle(100, ok);
  endtask

  // Reset in the middle of a conversion
  task automatic test_reset_convert;
    bit ok;
    checks++; if (overrun !== 1'b1 || timeout_err !== 1'b1) begin errors++; $display("[TB] FAIL sticky_flags: overrun %b timeout_err %b, required 1 and 1", overrun, timeout_err); end
    eoc_delay = 0;
    enable = 1'b1;
    wait_hold(1'b1, 10, ok);
    cycles(5);
    reset = 1'b1;
    cycles(1);
    checks++; if (adc_hold_digital !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_hold: hold %b busy %b, required 0 and 0", adc_hold_digital, busy); end
    checks++; if (avg_valid !== 1'b0 || avg_result_digital !== '0) begin errors++; $display("[TB] FAIL midreset_output: valid %b value %0d, required 0 and 0", avg_valid, avg_result_digital); end
    checks++; if (overrun !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL midreset_flags: overrun %b timeout_err %b, required 0 and 0", overrun, timeout_err); end
    reset = 1'b0; enable = 1'b0;
    cycles(2);
  endtask

  // Full-scale average, then a load coinciding with a handshake
  task automatic test_full_scale;
    bit ok;
    int e, h;
    avg_ready = 1'b1; eoc_delay = 12;
    for (int i = 0; i < 4; i++) adc_q.push_back(10'd1023);
    exp_q.push_back(10'd1023);
    h = hs_count;
    enable = 1'b1;
    wait_hs(h + 1, 400, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL full_scale_output: got %0d outputs, required 1", hs_count - h); end
    avg_ready = 1'b0;
    for (int i = 0; i < 4; i++) adc_q.push_back(10'd7);
    for (int i = 0; i < 4; i++) adc_q.push_back(10'd9);
    exp_q.push_back(10'd7); exp_q.push_back(10'd9);
    e = eoc_count;
    wait_eoc(e + 8, 600, ok);
    checks++; if (!ok || avg_valid !== 1'b1 || avg_result_digital !== 10'd7) begin errors++; $display("[TB] FAIL coincide_before: valid %b value %0d, required 1 and 7", avg_valid, avg_result_digital); end
    avg_ready = 1'b1;
    cycles(1);
    checks++; if (avg_valid !== 1'b1 || avg_result_digital !== 10'd9) begin errors++; $display("[TB] FAIL coincide_load: valid %b value %0d, required 1 and 9", avg_valid, avg_result_digital); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL coincide_overrun: got %b, required 0", overrun); end
    cycles(1);
    checks++; if (avg_valid !== 1'b0) begin errors++; $display("[TB] FAIL coincide_drain: valid %b, required 0", avg_valid); end
    enable = 1'b0;
    wait_idle(100, ok);
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    reset = 1'b1; enable = 1'b0; avg_ready = 1'b0;
    eoc_delay = 0; spurious_eoc = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    reset = 1'b0;
    cycles(1);
    test_average;
    test_overrun;
    test_timeout;
    test_enable_drop;
    test_reset_convert;
    test_full_scale;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_leftover: %0d results never produced, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
